dsp_fret_module: RTL

Release collector for reservation-station entries, the returning end of the dispatch free-list manager's interface. Issue ports release RSV entry indices, up to REL_PORTS per cycle. The block packs them in order into a small circular queue and drains up to four per cycle onto the free-list manager's return bus (ret_vld[3:0] / ret_entry_0..3). Draining honours the manager's stall, and the queue is discarded on a CSR trap flush.

---
 rtl/dsp_fret_module_pkg.sv | 14 +
 rtl/dsp_fret_pack_module.sv | 26 ++
 rtl/dsp_fret_module.sv | 124 ++++++++++++
 3 files changed

// File: rtl/dsp_fret_module_pkg.sv
// rtl/dsp_fret_module_pkg.sv - shared constants for the RSV release collector
package dsp_fret_module_pkg;

    // Reservation-station entry index width shared with the free-list manager
    localparam int RSV_IDX_WIDTH  = 6;
    // Lanes on the return bus towards the free-list manager
    localparam int FRET_RET_PORTS = 4;

    // Width needed to hold a popcount of n valid bits
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/dsp_fret_pack_module.sv
// rtl/dsp_fret_pack_module.sv - exclusive prefix popcount of release valids
module dsp_fret_pack_module
    import dsp_fret_module_pkg::*;
#(
    parameter int REL_PORTS = 6,
    parameter int OFF_W     = cnt_width(REL_PORTS)
) (
    input  logic [REL_PORTS-1:0]       rel_vld,
    output logic [REL_PORTS*OFF_W-1:0] rel_off,
    output logic [OFF_W-1:0]           rel_total
);

    logic [OFF_W-1:0] acc;

    // Port k's offset is the number of valid ports below it; total is the full popcount
    always_comb begin
        acc     = '0;
        rel_off = '0;
        for (int k = 0; k < REL_PORTS; k++) begin
            rel_off[k*OFF_W +: OFF_W] = acc;
            acc = acc + OFF_W'(rel_vld[k]);
        end
        rel_total = acc;
    end

endmodule

// File: rtl/dsp_fret_module.sv
// rtl/dsp_fret_module.sv - packs released RSV entries into a queue and drains them to the free-list manager
module dsp_fret_module
    import dsp_fret_module_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int REL_PORTS = 6,
    parameter int IDX_W     = RSV_IDX_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_csr_trap_flush,
    input  logic                       i_dsp_fmgr_stall,
    input  logic [REL_PORTS-1:0]       i_rel_vld,
    input  logic [REL_PORTS*IDX_W-1:0] i_rel_entry,
    output logic                       o_rel_rdy,
    output logic [3:0]                 o_dsp_fmgr_ret_vld,
    output logic [IDX_W-1:0]           o_dsp_fmgr_ret_entry_0,
    output logic [IDX_W-1:0]           o_dsp_fmgr_ret_entry_1,
    output logic [IDX_W-1:0]           o_dsp_fmgr_ret_entry_2,
    output logic [IDX_W-1:0]           o_dsp_fmgr_ret_entry_3,
    output logic                       o_fret_ovf,
    output logic [$clog2(DEPTH):0]     o_fret_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OFF_W = cnt_width(REL_PORTS);
    localparam int RP    = FRET_RET_PORTS;

    logic [IDX_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] cnt;
    logic             ovf;

    logic [REL_PORTS*OFF_W-1:0] rel_off;
    logic [OFF_W-1:0]           rel_total;
    logic [OFF_W-1:0]           off_arr [REL_PORTS];
    logic [REL_PORTS-1:0]       accept;
    logic [CNT_W-1:0]           free_cnt;
    logic [CNT_W-1:0]           push;
    logic [CNT_W-1:0]           pop;
    logic                       ovf_set;

    dsp_fret_pack_module #(
        .REL_PORTS (REL_PORTS),
        .OFF_W     (OFF_W)
    ) u_pack (
        .rel_vld   (i_rel_vld),
        .rel_off   (rel_off),
        .rel_total (rel_total)
    );

    // Accept only releases that land in free slots; free space ignores this cycle's pop
    always_comb begin
        free_cnt = CNT_W'(DEPTH) - cnt;
        accept   = '0;
        for (int k = 0; k < REL_PORTS; k++) begin
            off_arr[k] = rel_off[k*OFF_W +: OFF_W];
            accept[k]  = i_rel_vld[k] && (CNT_W'(off_arr[k]) < free_cnt);
        end
        ovf_set = CNT_W'(rel_total) > free_cnt;
        push    = ovf_set ? free_cnt : CNT_W'(rel_total);
        pop     = (cnt > CNT_W'(RP)) ? CNT_W'(RP) : cnt;
        if (i_dsp_fmgr_stall) begin
            pop = '0;
        end
        if (i_csr_trap_flush) begin
            accept  = '0;
            push    = '0;
            pop     = '0;
            ovf_set = 1'b0;
        end
    end

    // Pointer, occupancy and sticky overflow state; flush empties the queue and clears ovf
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            ovf    <= 1'b0;
        end else if (i_csr_trap_flush) begin
            cnt    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            ovf    <= 1'b0;
        end else begin
            cnt    <= cnt + push - pop;
            rd_ptr <= rd_ptr + PTR_W'(pop);
            wr_ptr <= wr_ptr + PTR_W'(push);
            if (ovf_set) begin
                ovf <= 1'b1;
            end
        end
    end

    // Write accepted releases into their packed slots; storage itself is not reset
    always_ff @(posedge clk) begin
        for (int k = 0; k < REL_PORTS; k++) begin
            if (accept[k] && !rst) begin
                mem[wr_ptr + PTR_W'(off_arr[k])] <= i_rel_entry[k*IDX_W +: IDX_W];
            end
        end
    end

    // Thermometer return valids from registered occupancy, suppressed during flush
    always_comb begin
        o_dsp_fmgr_ret_vld = '0;
        for (int k = 0; k < RP; k++) begin
            o_dsp_fmgr_ret_vld[k] = (cnt > CNT_W'(k)) && !i_csr_trap_flush;
        end
    end

    assign o_dsp_fmgr_ret_entry_0 = mem[rd_ptr];
    assign o_dsp_fmgr_ret_entry_1 = mem[rd_ptr + PTR_W'(1)];
    assign o_dsp_fmgr_ret_entry_2 = mem[rd_ptr + PTR_W'(2)];
    assign o_dsp_fmgr_ret_entry_3 = mem[rd_ptr + PTR_W'(3)];

    assign o_rel_rdy  = free_cnt >= CNT_W'(REL_PORTS);
    assign o_fret_ovf = ovf;
    assign o_fret_cnt = cnt;

endmodule
